jk_updown_counter: RTL



---
 rtl/counter_pkg.sv | 18 +
 rtl/jk_ff_sync.sv | 29 ++
 rtl/jk_updown_counter.sv | 70 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the JK-based counter library.
package counter_pkg;

   // {j,k} input encodings for a JK flip-flop
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Bits needed to hold values 0..v-1 (at least 1), for callers sizing WIDTH from MODULUS
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff_sync
   import counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 1'b0;
      end else begin
         case ({j, k})
            JK_RST:  r_q <= 1'b0;
            JK_SET:  r_q <= 1'b1;
            JK_TGL:  r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign q = r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Parametrised up/down modulo counter with parallel load, one JK flip-flop per bit.
module jk_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 2**WIDTH,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             carry_out
);

   localparam int               MAX_I = MODULUS - 1;
   localparam logic [WIDTH-1:0] MAXV  = MAX_I[WIDTH-1:0];

   generate
      if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
         $error("jk_updown_counter: MODULUS must lie in 2..2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic             w_at_max;
   logic             w_at_zero;

   assign w_at_max  = (w_q == MAXV);
   assign w_at_zero = (w_q == '0);

   // Wrap points come from explicit compares so non-power-of-two moduli work
   always_comb begin
      w_next = w_q;
      if (load) begin
         w_next = (load_val > MAXV) ? MAXV : load_val;
      end else if (en) begin
         if (up) begin
            if (w_at_max) w_next = (SATURATE != 0) ? w_q : '0;
            else          w_next = w_q + WIDTH'(1);
         end else begin
            if (w_at_zero) w_next = (SATURATE != 0) ? w_q : MAXV;
            else           w_next = w_q - WIDTH'(1);
         end
      end
   end

   // j=next, k=~next makes each flip-flop a plain set/reset of the next value
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         jk_ff_sync u_ff (
            .clk (clk),
            .rst (rst),
            .j   (w_next[i]),
            .k   (~w_next[i]),
            .q   (w_q[i])
         );
      end
   endgenerate

   assign q         = w_q;
   assign tc        = (up && w_at_max) || (!up && w_at_zero);
   assign carry_out = en && !load && tc;

endmodule
